// File: rtl/icache_dm_ro_pkg.sv
// icache_dm_ro_pkg: shared line type, word-select constants, default geometry and FSM state enum for the instruction cache
package icache_dm_ro_pkg;
  localparam int ICACHE_LINES = 64;
  localparam int WORD_W = 32;
  localparam int WORDS = 4;
  localparam logic [1:0] LAST_WORD = 2'd3;
  typedef logic [WORDS*WORD_W-1:0] line_t;
  typedef enum logic [1:0] {ST_IDLE, ST_MREQ, ST_MFILL, ST_RESP} state_t;
endpackage

// File: rtl/icache_line_array.sv
// icache_line_array: tag/data/valid storage; async read port (rd_*), word write (we/w_*), tag+valid write (tw/t_*), clear-all (clr), sync reset (rst)
module icache_line_array
  import icache_dm_ro_pkg::*;
#(
  parameter int LINES = ICACHE_LINES,
  parameter int IDX = $clog2(LINES),
  parameter int TAG_W = 22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX-1:0]   rd_idx,
  output logic [TAG_W-1:0] rd_tag,
  output line_t            rd_line,
  output logic             rd_valid,
  input  logic             we,
  input  logic [IDX-1:0]   w_idx,
  input  logic [1:0]       w_sel,
  input  logic [31:0]      w_data,
  input  logic             tw,
  input  logic [TAG_W-1:0] t_tag,
  input  logic             t_valid,
  input  logic             clr
);
  line_t            data [LINES];
  logic [TAG_W-1:0] tags [LINES];
  logic [LINES-1:0] valid;
  assign rd_tag = tags[rd_idx];
  assign rd_line = data[rd_idx];
  assign rd_valid = valid[rd_idx];
  always_ff @(posedge clk) begin
    if (we) data[w_idx][{w_sel, 5'd0} +: WORD_W] <= w_data;
    if (tw) tags[w_idx] <= t_tag;
  end
  always_ff @(posedge clk) begin
    if (rst || clr) valid <= '0;
    else if (tw) valid[w_idx] <= t_valid;
  end
endmodule

// File: rtl/icache_dm_ro.sv
// icache_dm_ro: read-only direct-mapped I-cache; fetch side i_valid/i_addr/i_rw -> o_ready/o_rvalid/o_rdata/o_err, i_flush invalidates, memory side o_mem_req_*/i_mem_req_ready/i_mem_res_* refills 4 beats
module icache_dm_ro
  import icache_dm_ro_pkg::*;
#(
  parameter int LINES = ICACHE_LINES,
  parameter int ADDR_LENGTH = 32,
  parameter int DATA_LENGTH = 128
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_valid,
  input  logic [ADDR_LENGTH-1:0] i_addr,
  input  logic                   i_rw,
  output logic                   o_ready,
  output logic                   o_rvalid,
  output logic [DATA_LENGTH-1:0] o_rdata,
  output logic                   o_err,
  input  logic                   i_flush,
  output logic                   o_mem_req_valid,
  output logic [ADDR_LENGTH-1:0] o_mem_req_addr,
  input  logic                   i_mem_req_ready,
  input  logic                   i_mem_res_valid,
  input  logic [31:0]            i_mem_res_data
);
  localparam int IDX = $clog2(LINES);
  localparam int TW = ADDR_LENGTH - 4 - IDX;
  state_t                 state;
  logic [1:0]             cnt;
  logic                   flush_pend;
  logic [ADDR_LENGTH-5:0] line_addr;
  logic                   idle, accept, rd_req, hit, beat, last, unused_lo;
  logic [IDX-1:0]         req_idx, fill_idx, rd_idx;
  logic [TW-1:0]          req_tag, fill_tag, rd_tag;
  line_t                  rd_line;
  logic                   rd_valid;
  assign unused_lo = ^i_addr[3:0];
  assign idle = state == ST_IDLE || state == ST_RESP;
  assign o_ready = idle;
  assign o_mem_req_valid = state == ST_MREQ;
  assign o_mem_req_addr = {line_addr, 4'd0};
  assign req_idx = i_addr[4 +: IDX];
  assign req_tag = i_addr[ADDR_LENGTH-1 -: TW];
  assign fill_idx = line_addr[0 +: IDX];
  assign fill_tag = line_addr[ADDR_LENGTH-5 -: TW];
  assign rd_idx = idle ? req_idx : fill_idx;
  assign accept = i_valid && idle;
  assign rd_req = accept && !i_rw;
  // a flush taking effect at this edge (new or pending) makes every lookup a miss
  assign hit = rd_valid && rd_tag == req_tag && !i_flush && !flush_pend;
  assign beat = state == ST_MFILL && i_mem_res_valid;
  assign last = beat && cnt == LAST_WORD;
  icache_line_array #(.LINES(LINES), .IDX(IDX), .TAG_W(TW)) u_array (
    .clk(i_clk), .rst(i_reset), .rd_idx(rd_idx), .rd_tag(rd_tag), .rd_line(rd_line), .rd_valid(rd_valid),
    .we(beat), .w_idx(fill_idx), .w_sel(cnt), .w_data(i_mem_res_data),
    .tw(last), .t_tag(fill_tag), .t_valid(!(flush_pend || i_flush)),
    .clr(idle && (i_flush || flush_pend))
  );
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= ST_IDLE;
      cnt <= '0;
      flush_pend <= 1'b0;
      line_addr <= '0;
      o_rvalid <= 1'b0;
      o_rdata <= '0;
      o_err <= 1'b0;
    end else begin
      o_err <= accept && i_rw;
      if (idle) begin
        flush_pend <= 1'b0;
        state <= ST_IDLE;
        if (rd_req) begin
          o_rvalid <= hit;
          if (hit) o_rdata <= rd_line;
          else begin
            line_addr <= i_addr[ADDR_LENGTH-1:4];
            state <= ST_MREQ;
          end
        end
      end else begin
        if (i_flush) flush_pend <= 1'b1;
        if (state == ST_MREQ && i_mem_req_ready) begin
          state <= ST_MFILL;
          cnt <= '0;
        end
        if (beat) cnt <= cnt + 2'd1;
        if (last) begin
          state <= ST_RESP;
          o_rvalid <= 1'b1;
          o_rdata <= {i_mem_res_data, rd_line[3*WORD_W-1:0]};
        end
      end
    end
  end
endmodule

// File: tb/tb_icache_dm_ro.sv
// tb_icache_dm_ro: randomized self-checking bench for icache_dm_ro against a line-level cache model
module tb_icache_dm_ro;
  logic clk = 1'b0;
  logic i_reset = 1'b1, i_valid = 1'b0, i_rw = 1'b0, i_flush = 1'b0;
  logic [31:0] i_addr = '0;
  logic o_ready, o_rvalid, o_err, o_mem_req_valid;
  logic [127:0] o_rdata;
  logic [31:0] o_mem_req_addr;
  logic i_mem_req_ready = 1'b0, i_mem_res_valid = 1'b0;
  logic [31:0] i_mem_res_data = '0;
  int n_cmp = 0, n_bad = 0;
  bit mvalid [64];
  logic [21:0] mtag [64];
  logic [31:0] mem [bit [31:0]];
  logic exp_rvalid = 1'b0;
  logic [127:0] exp_rdata = '0;

  always #5 clk = ~clk;

  icache_dm_ro dut (
    .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid), .i_addr(i_addr), .i_rw(i_rw),
    .o_ready(o_ready), .o_rvalid(o_rvalid), .o_rdata(o_rdata), .o_err(o_err), .i_flush(i_flush),
    .o_mem_req_valid(o_mem_req_valid), .o_mem_req_addr(o_mem_req_addr), .i_mem_req_ready(i_mem_req_ready),
    .i_mem_res_valid(i_mem_res_valid), .i_mem_res_data(i_mem_res_data)
  );

  function automatic logic [31:0] memw(input bit [31:0] a);
    if (!mem.exists(a)) mem[a] = $urandom;
    return mem[a];
  endfunction

  function automatic logic [127:0] memline(input bit [31:0] b);
    return {memw(b + 12), memw(b + 8), memw(b + 4), memw(b)};
  endfunction

  task automatic model_clear();
    foreach (mvalid[i]) mvalid[i] = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input int wt, input int flush_beat, input bit flush_now);
    logic [31:0] b;
    int idx;
    logic [21:0] tg;
    bit hit;
    logic [127:0] line;
    b = {a[31:4], 4'd0};
    idx = int'(a[9:4]);
    tg = a[31:10];
    if (flush_now) model_clear();
    hit = mvalid[idx] && mtag[idx] == tg;
    line = memline(b);
    i_valid = 1'b1; i_addr = a; i_rw = 1'b0; i_flush = flush_now;
    @(negedge clk);
    i_valid = 1'b0; i_flush = 1'b0; i_addr = $urandom;
    if (hit) begin
      n_cmp++;
      if ({o_rvalid, o_rdata, o_mem_req_valid, o_ready} !== {1'b1, line, 1'b0, 1'b1}) begin
        n_bad++;
        $display("FAIL hit addr=%h got rvalid=%b rdata=%h mreq=%b ready=%b want 1 %h 0 1", a, o_rvalid, o_rdata, o_mem_req_valid, o_ready, line);
      end
      exp_rvalid = 1'b1; exp_rdata = line;
    end else begin
      n_cmp++;
      if ({o_rvalid, o_mem_req_valid, o_ready, o_mem_req_addr} !== {1'b0, 1'b1, 1'b0, b}) begin
        n_bad++;
        $display("FAIL miss_req addr=%h got rvalid=%b mreq=%b ready=%b maddr=%h want 0 1 0 %h", a, o_rvalid, o_mem_req_valid, o_ready, o_mem_req_addr, b);
      end
      for (int w = 0; w < wt; w++) begin
        i_mem_req_ready = 1'b0; i_mem_res_valid = 1'b1; i_mem_res_data = $urandom;
        @(negedge clk);
        n_cmp++;
        if ({o_mem_req_valid, o_ready, o_mem_req_addr} !== {1'b1, 1'b0, b}) begin
          n_bad++;
          $display("FAIL req_hold cyc=%0d got mreq=%b ready=%b maddr=%h want 1 0 %h", w, o_mem_req_valid, o_ready, o_mem_req_addr, b);
        end
      end
      i_mem_res_valid = 1'b0; i_mem_req_ready = 1'b1;
      @(negedge clk);
      i_mem_req_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
        repeat ($urandom_range(0, 1)) @(negedge clk);
        i_mem_res_valid = 1'b1; i_mem_res_data = line[32*k +: 32]; i_flush = (k == flush_beat);
        @(negedge clk);
        i_mem_res_valid = 1'b0; i_flush = 1'b0;
        if (k < 3) begin
          n_cmp++;
          if ({o_rvalid, o_ready} !== 2'b00) begin
            n_bad++;
            $display("FAIL fill_busy beat=%0d got rvalid=%b ready=%b want 0 0", k, o_rvalid, o_ready);
          end
        end
      end
      n_cmp++;
      if ({o_rvalid, o_rdata, o_ready} !== {1'b1, line, 1'b1}) begin
        n_bad++;
        $display("FAIL miss_resp addr=%h got rvalid=%b rdata=%h ready=%b want 1 %h 1", a, o_rvalid, o_rdata, o_ready, line);
      end
      exp_rvalid = 1'b1; exp_rdata = line;
      if (flush_beat >= 0) model_clear();
      else begin
        mvalid[idx] = 1'b1; mtag[idx] = tg;
      end
    end
  endtask

  task automatic do_flush();
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    model_clear();
  endtask

  task automatic do_write(input logic [31:0] a);
    i_valid = 1'b1; i_rw = 1'b1; i_addr = a;
    @(negedge clk);
    i_valid = 1'b0; i_rw = 1'b0;
    n_cmp++;
    if ({o_err, o_rvalid, o_rdata, o_ready} !== {1'b1, exp_rvalid, exp_rdata, 1'b1}) begin
      n_bad++;
      $display("FAIL write_err got err=%b rvalid=%b rdata=%h ready=%b want 1 %b %h 1", o_err, o_rvalid, o_rdata, o_ready, exp_rvalid, exp_rdata);
    end
    @(negedge clk);
    n_cmp++;
    if (o_err !== 1'b0) begin
      n_bad++;
      $display("FAIL write_pulse got err=%b want 0", o_err);
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    repeat (2) @(negedge clk);
    i_reset = 1'b0;
    model_clear();
    exp_rvalid = 1'b0; exp_rdata = '0;
    n_cmp++;
    if ({o_ready, o_rvalid, o_rdata, o_err, o_mem_req_valid, o_mem_req_addr} !== {1'b1, 1'b0, 128'd0, 1'b0, 1'b0, 32'd0}) begin
      n_bad++;
      $display("FAIL reset got ready=%b rvalid=%b rdata=%h err=%b mreq=%b maddr=%h want 1 0 0 0 0 0", o_ready, o_rvalid, o_rdata, o_err, o_mem_req_valid, o_mem_req_addr);
    end
  endtask

  task automatic test_cold_hit();
    mem[32'h1000] = 32'h11111111; mem[32'h1004] = 32'h22222222;
    mem[32'h1008] = 32'h33333333; mem[32'h100C] = 32'h44444444;
    do_read(32'h1000, 0, -1, 1'b0);
    n_cmp++;
    if (o_rdata !== 128'h44444444_33333333_22222222_11111111) begin
      n_bad++;
      $display("FAIL cold_data got %h want 44444444333333332222222211111111", o_rdata);
    end
    do_read(32'h100C, 0, -1, 1'b0);
  endtask

  task automatic test_conflict();
    do_read(32'h1400, 0, -1, 1'b0);
    do_read(32'h1000, 0, -1, 1'b0);
  endtask

  task automatic test_backpressure();
    do_read(32'h2000, 5, -1, 1'b0);
  endtask

  task automatic test_flush();
    do_read(32'h1000, 0, -1, 1'b0);
    do_flush();
    do_read(32'h1000, 0, -1, 1'b0);
    do_read(32'h3000, 1, 2, 1'b0);
    do_read(32'h3000, 0, -1, 1'b0);
    do_read(32'h1000, 0, -1, 1'b1);
  endtask

  task automatic test_write();
    do_write(32'h1000);
  endtask

  task automatic test_reset_mid();
    logic [127:0] line;
    do_flush();
    line = memline(32'h5000);
    i_valid = 1'b1; i_addr = 32'h5000;
    @(negedge clk);
    i_valid = 1'b0; i_mem_req_ready = 1'b1;
    @(negedge clk);
    i_mem_req_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      i_mem_res_valid = 1'b1; i_mem_res_data = line[32*k +: 32]; i_reset = (k == 2);
      @(negedge clk);
    end
    i_reset = 1'b0; i_mem_res_valid = 1'b0;
    model_clear();
    exp_rvalid = 1'b0; exp_rdata = '0;
    n_cmp++;
    if ({o_ready, o_rvalid, o_mem_req_valid} !== 3'b100) begin
      n_bad++;
      $display("FAIL reset_mid got ready=%b rvalid=%b mreq=%b want 1 0 0", o_ready, o_rvalid, o_mem_req_valid);
    end
    i_mem_res_valid = 1'b1; i_mem_res_data = line[127:96];
    @(negedge clk);
    i_mem_res_valid = 1'b0;
    n_cmp++;
    if ({o_ready, o_rvalid} !== 2'b10) begin
      n_bad++;
      $display("FAIL late_beat got ready=%b rvalid=%b want 1 0", o_ready, o_rvalid);
    end
    do_read(32'h5000, 0, -1, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] a;
    int r;
    for (int it = 0; it < 80; it++) begin
      r = $urandom_range(0, 9);
      a = 32'h1000 + ($urandom_range(0, 2) << 10) + ($urandom_range(0, 3) << 4) + $urandom_range(0, 15);
      if (r < 7) do_read(a, $urandom_range(0, 3), ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1, $urandom_range(0, 7) == 0);
      else if (r == 7) do_flush();
      else do_write(a);
    end
  endtask

  initial begin
    test_reset();
    test_cold_hit();
    test_conflict();
    test_backpressure();
    test_flush();
    test_write();
    test_reset_mid();
    test_random();
    test_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
